// File: rtl/pkt_out_arb_pkg.sv
// Shared types and constants for the packet output arbiter.
package pkt_out_arb_pkg;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_LIMIT_WIDTH = 16;
    localparam int unsigned CUR_CH_W        = 3;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Channel index width: clog2 of the channel count, never below 1 bit.
    function automatic int unsigned ch_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational channel picker: cyclic first-one search after ptr, or
// strict lowest-index priority when PKT_OUT_ARB_PRIO_EN is defined.
module rr_select
    import pkt_out_arb_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CH_W = ch_idx_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            found_c,
    output logic [CH_W-1:0] sel_c
);

`ifdef PKT_OUT_ARB_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Walk downwards so the lowest-numbered requester is the last writer.
    always_comb begin
        found_c = 1'b0;
        sel_c   = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (req[CH_W'(i)]) begin
                found_c = 1'b1;
                sel_c   = CH_W'(i);
            end
        end
    end
`else
    // Walk from the farthest to the nearest position after ptr so the
    // nearest requester wins.
    always_comb begin
        int idx;
        found_c = 1'b0;
        sel_c   = '0;
        idx     = 0;
        for (int k = int'(N_CH); k >= 1; k--) begin
            idx = (int'(ptr) + k) % int'(N_CH);
            if (req[CH_W'(idx)]) begin
                found_c = 1'b1;
                sel_c   = CH_W'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/pkt_out_arbiter.sv
// Packet-atomic merge of N_CH channel streams into one output FIFO, with
// host output-limit window and idle detect. Optional: PKT_OUT_ARB_PRIO_EN.
module pkt_out_arbiter
    import pkt_out_arb_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned LIMIT_WIDTH     = DEF_LIMIT_WIDTH,
    parameter int unsigned IDLE_DELAY_BITS = 6
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [N_CH*WIDTH-1:0]   ch_data,
    input  logic [N_CH-1:0]         ch_valid,
    input  logic [N_CH-1:0]         ch_last,
    output logic [N_CH-1:0]         ch_ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    wr_en,
    input  logic                    almost_full,
    input  logic                    mode_limit,
    input  logic                    reg_output_limit,
    output logic [LIMIT_WIDTH-1:0]  output_limit,
    output logic                    output_limit_not_done,
    output logic [CUR_CH_W-1:0]     cur_ch,
    output logic                    idle
);

    localparam int unsigned CH_W = ch_idx_width(N_CH);
    localparam logic [LIMIT_WIDTH-1:0]     CNT_MAX  = '1;
    localparam logic [IDLE_DELAY_BITS-1:0] IDLE_MAX = '1;

    arb_state_e                 state;
    logic [CH_W-1:0]            rr_ptr;
    logic [CH_W-1:0]            cur_idx;
    logic [LIMIT_WIDTH-1:0]     lim_cnt;
    logic [IDLE_DELAY_BITS-1:0] idle_cnt;

    logic                       found_c;
    logic [CH_W-1:0]            sel_c;
    logic                       credit_ok_c;
    logic                       accept_c;
    logic                       cur_last_c;
    logic [WIDTH-1:0]           cur_word_c;
    logic                       activity_c;
    logic [IDLE_DELAY_BITS-1:0] idle_cnt_nxt_c;

    rr_select #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_select (
        .req     (ch_valid),
        .ptr     (rr_ptr),
        .found_c (found_c),
        .sel_c   (sel_c)
    );

    assign credit_ok_c = ~mode_limit | (lim_cnt != CNT_MAX);
    assign cur_ch      = CUR_CH_W'(cur_idx);

    // Only the granted channel may be accepted, and only while transferring.
    always_comb begin
        ch_ready   = '0;
        cur_word_c = '0;
        cur_last_c = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (CH_W'(i) == cur_idx) begin
                cur_word_c  = ch_data[i*WIDTH +: WIDTH];
                cur_last_c  = ch_last[i];
                ch_ready[i] = (state == ST_XFER) & ch_valid[i] & ~almost_full & credit_ok_c;
            end
        end
    end

    assign accept_c = |ch_ready;

    // Arbitration FSM and registered output word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_ARB;
            rr_ptr  <= CH_W'(N_CH - 1);
            cur_idx <= '0;
            dout    <= '0;
            wr_en   <= 1'b0;
        end else begin
            wr_en <= accept_c;
            if (accept_c) begin
                dout <= cur_word_c;
            end
            case (state)
                ST_ARB: begin
                    if (found_c) begin
                        cur_idx <= sel_c;
                        rr_ptr  <= sel_c;
                        state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept_c && cur_last_c) begin
                        state <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    // Output-limit window: a word accepted on the latch cycle opens the new window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lim_cnt               <= '0;
            output_limit          <= '0;
            output_limit_not_done <= 1'b0;
        end else if (reg_output_limit) begin
            output_limit          <= lim_cnt;
            output_limit_not_done <= (lim_cnt == CNT_MAX);
            lim_cnt               <= accept_c ? LIMIT_WIDTH'(1) : '0;
        end else if (accept_c && (lim_cnt != CNT_MAX)) begin
            lim_cnt <= lim_cnt + 1'b1;
        end
    end

    assign activity_c = (|ch_valid) | wr_en | (state != ST_ARB);

    always_comb begin
        idle_cnt_nxt_c = idle_cnt;
        if (activity_c) begin
            idle_cnt_nxt_c = '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt_nxt_c = idle_cnt + 1'b1;
        end
    end

    // Idle delay: counter parks at its maximum, which is what idle reports.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idle_cnt <= IDLE_MAX;
            idle     <= 1'b1;
        end else begin
            idle_cnt <= idle_cnt_nxt_c;
            idle     <= (idle_cnt_nxt_c == IDLE_MAX);
        end
    end

endmodule
